uart_tx_arbiter: RTL and testbench

Shares the single UART transmit link between NUM_REQ on-chip message producers, such as game-state and score sources. Each accepted request becomes one MESSAGE_SIZE-bit frame of the form {tag, payload}, which is handed to a handshake-capable UART transmitter. Arbitration is round-robin and fair. When the link has been idle for IDLE_TIMEOUT cycles, the block inserts a heartbeat frame so the receiving board can detect loss of link.

---
 rtl/uart_link_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 128 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared definitions for the UART message link: frame geometry, heartbeat tag and
// the transmit-side arbiter state encoding.
package uart_link_pkg;

    localparam int NUM_REQ      = 4;
    localparam int PAYLOAD_W    = 13;
    localparam int TAG_W        = $clog2(NUM_REQ) + 1;
    localparam int MESSAGE_SIZE = TAG_W + PAYLOAD_W;

    // One bit wider than a requester index, so all-ones never collides with a real source.
    localparam logic [TAG_W-1:0] HEARTBEAT_TAG = {TAG_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DONE = 2'd2
    } link_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request strictly after the last
// granted index, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_last) + k) % NUM_REQ;
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = IDX_W'(w_pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ producers; each grant becomes one
// {tag, payload} frame, and a heartbeat frame is sent after IDLE_TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = uart_link_pkg::NUM_REQ,
    parameter int PAYLOAD_W    = uart_link_pkg::PAYLOAD_W,
    parameter int TAG_W        = $clog2(NUM_REQ) + 1,
    parameter int MESSAGE_SIZE = TAG_W + PAYLOAD_W,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*PAYLOAD_W-1:0]  i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [MESSAGE_SIZE-1:0]       o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    input  logic                          i_tx_done,
    output logic                          o_busy,
    output logic [15:0]                   o_frames_sent,
    output logic [7:0]                    o_heartbeats_sent
);

    import uart_link_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(IDLE_TIMEOUT);
    localparam logic [TAG_W-1:0] HB_TAG = {TAG_W{1'b1}};

    link_state_e              r_state;
    link_state_e              w_state_nxt;
    logic [MESSAGE_SIZE-1:0]  r_tx_data;
    logic [IDX_W-1:0]         r_rr_last;
    logic [CNT_W-1:0]         r_idle_cnt;
    logic [15:0]              r_frames;
    logic [7:0]               r_hbs;

    logic [NUM_REQ-1:0]       w_grant;
    logic [IDX_W-1:0]         w_idx;
    logic                     w_any;
    logic [PAYLOAD_W-1:0]     w_payload;
    logic                     w_hb_due;
    logic                     w_load_req;
    logic                     w_load_hb;
    logic                     w_frame_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_last  (r_rr_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_payload = i_req_data[int'(w_idx)*PAYLOAD_W +: PAYLOAD_W];
    assign w_hb_due  = (r_idle_cnt == CNT_W'(IDLE_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_req   = 1'b0;
        w_load_hb    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                // A pending request always beats a heartbeat falling due in the same cycle.
                if (w_any) begin
                    w_load_req  = 1'b1;
                    w_state_nxt = OFFER;
                end else if (w_hb_due) begin
                    w_load_hb   = 1'b1;
                    w_state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (i_tx_ready) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_tx_done) begin
                    w_frame_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_data  <= '0;
            r_rr_last  <= IDX_W'(NUM_REQ - 1);
            r_idle_cnt <= '0;
            r_frames   <= '0;
            r_hbs      <= '0;
        end else begin
            if (w_load_req) begin
                r_tx_data  <= {TAG_W'(w_idx), w_payload};
                r_rr_last  <= w_idx;
                r_idle_cnt <= '0;
            end else if (w_load_hb) begin
                r_tx_data  <= {HB_TAG, {PAYLOAD_W{1'b0}}};
                r_idle_cnt <= '0;
            end else if (r_state == IDLE) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_frames <= r_frames + 16'd1;
                if (r_tx_data[MESSAGE_SIZE-1 -: TAG_W] == HB_TAG) r_hbs <= r_hbs + 8'd1;
            end
        end
    end

    // Gated by rst so the accept strobe is also forced low while reset is held.
    assign o_req_ready       = (r_state == IDLE && !rst) ? w_grant : '0;
    assign o_tx_valid        = (r_state == OFFER);
    assign o_tx_data         = r_tx_data;
    assign o_busy            = (r_state != IDLE);
    assign o_frames_sent     = r_frames;
    assign o_heartbeats_sent = r_hbs;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// transactions against a round-robin / frame-count reference model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int PW = 13;
    localparam int TW = 3;
    localparam int MW = TW + PW;
    localparam int DW = N * PW;
    localparam int TO = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [MW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          tx_done;
    logic          busy;
    logic [15:0]   frames_sent;
    logic [7:0]    heartbeats_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last;
    int model_frames;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .PAYLOAD_W    (PW),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_req_valid       (req_valid),
        .i_req_data        (req_data),
        .o_req_ready       (req_ready),
        .o_tx_data         (tx_data),
        .o_tx_valid        (tx_valid),
        .i_tx_ready        (tx_ready),
        .i_tx_done         (tx_done),
        .o_busy            (busy),
        .o_frames_sent     (frames_sent),
        .o_heartbeats_sent (heartbeats_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        if (idx >= 0) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic apply_reset();
        rst = 1'b1; req_valid = '0; req_data = '0; tx_ready = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = N - 1;
        model_frames = 0;
    endtask

    // Called at a negedge after driving inputs; returns just after the negedge on
    // which req_ready is seen high (the accepting posedge follows).
    task automatic wait_grant(output logic [N-1:0] g, output bit ok);
        ok = 1'b0; g = '0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (req_ready != '0) begin g = req_ready; ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_data = rand_data(); tx_ready = 1'b1; tx_done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_checks++; if (tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data: got %h want 0", tx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (frames_sent !== 16'd0) begin n_fail++; $display("FAIL reset_frames: got %0d want 0", frames_sent); end
        n_checks++; if (heartbeats_sent !== 8'd0) begin n_fail++; $display("FAIL reset_hb: got %0d want 0", heartbeats_sent); end
    endtask

    task automatic test_single();
        logic [N-1:0] g; bit ok; logic [MW-1:0] exp_f;
        apply_reset();
        tx_ready = 1'b1;
        req_data[2*PW +: PW] = 13'h0ABC;
        req_valid = 4'b0100;
        exp_f = {3'b010, 13'h0ABC};
        wait_grant(g, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_grant_timeout: got none want 0100"); end
        n_checks++; if (g !== 4'b0100) begin n_fail++; $display("FAIL single_req_ready: got %b want 0100", g); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL single_ready_offer: got %b want 0", req_ready); end
        n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL single_tx_valid: got %b want 1", tx_valid); end
        n_checks++; if (tx_data !== exp_f) begin n_fail++; $display("FAIL single_tx_data: got %h want %h", tx_data, exp_f); end
        repeat (19) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_done: got valid=%b busy=%b want 0/1", tx_valid, busy); end
        pulse_done();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL single_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] g; bit ok; int exp_i, obs, prev_obs; logic [MW-1:0] exp_f;
        apply_reset();
        tx_ready = 1'b1; req_data = rand_data(); req_valid = '1;
        prev_obs = -1;
        for (int f = 0; f < 8; f++) begin
            wait_grant(g, ok);
            exp_i = rr_pick(req_valid, model_last);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL fair_timeout: frame %0d no grant", f); end
            n_checks++; if (g !== onehot(exp_i)) begin n_fail++; $display("FAIL fair_order: frame %0d got %b want %b", f, g, onehot(exp_i)); end
            obs = -1;
            for (int i = 0; i < N; i++) if (g[i]) obs = i;
            n_checks++; if (obs == prev_obs) begin n_fail++; $display("FAIL fair_repeat: requester %0d granted twice in a row", obs); end
            prev_obs = obs;
            model_last = exp_i;
            exp_f = {TW'(exp_i), req_data[exp_i*PW +: PW]};
            @(negedge clk); #1;
            n_checks++; if (tx_data !== exp_f) begin n_fail++; $display("FAIL fair_tx_data: got %h want %h", tx_data, exp_f); end
            @(negedge clk);
            pulse_done();
            model_frames++;
            n_checks++; if (frames_sent !== 16'(model_frames)) begin n_fail++; $display("FAIL fair_frames: got %0d want %0d", frames_sent, model_frames); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g; bit ok; logic [MW-1:0] exp_f;
        apply_reset();
        tx_ready = 1'b0; req_data = rand_data(); req_valid = 4'b0010;
        exp_f = {3'b001, req_data[PW +: PW]};
        wait_grant(g, ok);
        n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL bp_grant: got %b want 0010", g); end
        @(negedge clk);
        req_valid = 4'b1011; req_data = rand_data();
        for (int c = 0; c < 100; c++) begin
            #1;
            n_checks++; if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %b want 1", c, tx_valid); end
            n_checks++; if (tx_data !== exp_f) begin n_fail++; $display("FAIL bp_data: cycle %0d got %h want %h", c, tx_data, exp_f); end
            n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b want 0", c, req_ready); end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got valid=%b busy=%b want 0/1", tx_valid, busy); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_ready_wait: got %b want 0", req_ready); end
        req_valid = '0;
        pulse_done();
        n_checks++; if (frames_sent !== 16'd1) begin n_fail++; $display("FAIL bp_frames: got %0d want 1", frames_sent); end
    endtask

    task automatic test_spurious();
        logic [N-1:0] g; bit ok;
        apply_reset();
        @(negedge clk);
        pulse_done();
        #1;
        n_checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || frames_sent !== 16'd0) begin n_fail++; $display("FAIL spur_idle: got busy=%b valid=%b frames=%0d want 0/0/0", busy, tx_valid, frames_sent); end
        req_data = rand_data(); req_valid = 4'b1000;
        wait_grant(g, ok);
        n_checks++; if (g !== 4'b1000) begin n_fail++; $display("FAIL spur_grant: got %b want 1000", g); end
        @(negedge clk);
        req_valid = '0;
        pulse_done();
        #1;
        n_checks++; if (tx_valid !== 1'b1 || busy !== 1'b1 || frames_sent !== 16'd0) begin n_fail++; $display("FAIL spur_offer: got valid=%b busy=%b frames=%0d want 1/1/0", tx_valid, busy, frames_sent); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        pulse_done();
        n_checks++; if (frames_sent !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL spur_done: got frames=%0d busy=%b want 1/0", frames_sent, busy); end
    endtask

    task automatic test_heartbeat();
        logic [N-1:0] g; bit ok; logic [MW-1:0] exp_f;
        apply_reset();
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (tx_valid !== (k == TO)) begin n_fail++; $display("FAIL hb_timing: cycle %0d got valid=%b want %b", k, tx_valid, (k == TO)); end
        end
        exp_f = {3'b111, 13'h0};
        n_checks++; if (tx_data !== exp_f) begin n_fail++; $display("FAIL hb_frame: got %h want %h", tx_data, exp_f); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        pulse_done();
        n_checks++; if (heartbeats_sent !== 8'd1 || frames_sent !== 16'd1) begin n_fail++; $display("FAIL hb_counts: got hb=%0d frames=%0d want 1/1", heartbeats_sent, frames_sent); end
        // Request lands in the cycle the heartbeat would fall due.
        apply_reset();
        repeat (TO - 1) @(negedge clk);
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL hb_early: got valid=%b want 0", tx_valid); end
        req_data = rand_data(); req_valid = 4'b0001;
        exp_f = {3'b000, req_data[0 +: PW]};
        wait_grant(g, ok);
        n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL hb_req_grant: got %b want 0001", g); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (tx_data !== exp_f) begin n_fail++; $display("FAIL hb_req_frame: got %h want %h", tx_data, exp_f); end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        pulse_done();
        n_checks++; if (heartbeats_sent !== 8'd0 || frames_sent !== 16'd1) begin n_fail++; $display("FAIL hb_req_counts: got hb=%0d frames=%0d want 0/1", heartbeats_sent, frames_sent); end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] g; bit ok;
        apply_reset();
        tx_ready = 1'b1; req_data = rand_data(); req_valid = '1;
        wait_grant(g, ok);
        n_checks++; if (g !== 4'b0001) begin n_fail++; $display("FAIL rmid_first: got %b want 0001", g); end
        @(negedge clk);
        @(negedge clk);
        pulse_done();
        wait_grant(g, ok);
        n_checks++; if (g !== 4'b0010) begin n_fail++; $display("FAIL rmid_second: got %b want 0010", g); end
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b1 || frames_sent !== 16'd1) begin n_fail++; $display("FAIL rmid_pre: got busy=%b frames=%0d want 1/1", busy, frames_sent); end
        rst = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_async: got valid=%b busy=%b want 0/0", tx_valid, busy); end
        n_checks++; if (frames_sent !== 16'd0 || heartbeats_sent !== 8'd0) begin n_fail++; $display("FAIL rmid_counters: got frames=%0d hb=%0d want 0/0", frames_sent, heartbeats_sent); end
        n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rmid_ready: got %b want 0", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rmid_after: got %b want 0001", req_ready); end
    endtask

    task automatic test_random();
        logic [N-1:0] g, mask; bit ok; int exp_i, stall; logic [MW-1:0] exp_f;
        apply_reset();
        for (int t = 0; t < 40; t++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            req_valid = mask; req_data = rand_data();
            wait_grant(g, ok);
            exp_i = rr_pick(mask, model_last);
            n_checks++; if (!ok || g !== onehot(exp_i)) begin n_fail++; $display("FAIL rand_grant: txn %0d mask %b got %b want %b", t, mask, g, onehot(exp_i)); end
            model_last = exp_i;
            exp_f = {TW'(exp_i), req_data[exp_i*PW +: PW]};
            @(negedge clk);
            req_valid = N'($urandom()); req_data = rand_data();
            stall = $urandom_range(0, 4);
            for (int s = 0; s <= stall; s++) begin
                #1;
                n_checks++; if (tx_valid !== 1'b1 || tx_data !== exp_f) begin n_fail++; $display("FAIL rand_offer: txn %0d got valid=%b data=%h want 1/%h", t, tx_valid, tx_data, exp_f); end
                n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL rand_ready: txn %0d got %b want 0", t, req_ready); end
                if (s == stall) tx_ready = 1'b1;
                @(negedge clk);
            end
            tx_ready = 1'b0;
            #1;
            n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rand_accept: txn %0d got valid=%b want 0", t, tx_valid); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            pulse_done();
            model_frames++;
            n_checks++; if (frames_sent !== 16'(model_frames)) begin n_fail++; $display("FAIL rand_frames: got %0d want %0d", frames_sent, model_frames); end
        end
        n_checks++; if (heartbeats_sent !== 8'd0) begin n_fail++; $display("FAIL rand_hb: got %0d want 0", heartbeats_sent); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_spurious();
        test_heartbeat();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
